// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - fixed on-time gate driver with dead time and off-period handshake
module pwm_gen #(
  parameter int ON_TIME   = 40,
  parameter int CNT_WIDTH = 18,
  parameter int DEAD_TIME = 2,
  parameter int MIN_OFF   = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 run,
  input  logic                 fault,
  input  logic                 pwm_rdy,
  input  logic [CNT_WIDTH-1:0] off_div,
  output logic                 pwm_out,
  output logic                 pwm_n_out,
  output logic                 pwm_en,
  output logic                 fault_lat,
  output logic [CNT_WIDTH-1:0] off_lat
);

  localparam logic [2:0] ST_STOP = 3'd0;
  localparam logic [2:0] ST_ON   = 3'd1;
  localparam logic [2:0] ST_DT_A = 3'd2;
  localparam logic [2:0] ST_OFF  = 3'd3;
  localparam logic [2:0] ST_DT_B = 3'd4;

  localparam bit                   HAS_DT    = DEAD_TIME > 0;
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ON_LOAD   = CNT_WIDTH'(ON_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] DT_LOAD   = CNT_WIDTH'(HAS_DT ? DEAD_TIME - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] MIN_OFF_V = CNT_WIDTH'(MIN_OFF);

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] off_clamped;
  logic                 cnt_zero;
  logic                 load_off;

  assign cnt_zero    = (cnt == '0);
  assign off_clamped = (off_div < MIN_OFF_V) ? MIN_OFF_V : off_div;

  // Fault and run are checked last so they override any timer expiry.
  always_comb begin
    next_state = state;
    case (state)
      ST_STOP: if (run && !fault_lat) next_state = ST_ON;
      ST_ON:   if (cnt_zero) next_state = HAS_DT ? ST_DT_A : ST_OFF;
      ST_DT_A: if (cnt_zero) next_state = ST_OFF;
      ST_OFF:  if (cnt_zero) next_state = HAS_DT ? ST_DT_B : ST_ON;
      ST_DT_B: if (cnt_zero) next_state = ST_ON;
      default: next_state = ST_STOP;
    endcase
    if (fault || !run) next_state = ST_STOP;
  end

  // A start from STOP always takes the requested period; a running wrap needs pwm_rdy.
  always_comb begin
    load_off = 1'b0;
    if (next_state == ST_ON && state != ST_ON) load_off = (state == ST_STOP) || pwm_rdy;
  end

  // Counter holds (remaining cycles - 1) so the full CNT_WIDTH range of off_lat fits.
  always_comb begin
    cnt_next = cnt;
    if (next_state != state) begin
      case (next_state)
        ST_ON:            cnt_next = ON_LOAD;
        ST_DT_A, ST_DT_B: cnt_next = DT_LOAD;
        ST_OFF:           cnt_next = off_lat - ONE;
        default:          cnt_next = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_next = cnt - ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_STOP;
      cnt       <= '0;
      pwm_out   <= 1'b0;
      pwm_n_out <= 1'b0;
      pwm_en    <= 1'b0;
      fault_lat <= 1'b0;
      off_lat   <= MIN_OFF_V;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      pwm_out   <= (next_state == ST_ON);
      pwm_n_out <= (next_state == ST_OFF);
      pwm_en    <= (next_state == ST_OFF) && (state != ST_OFF);
      if (fault)     fault_lat <= 1'b1;
      else if (!run) fault_lat <= 1'b0;
      if (load_off)  off_lat <= off_clamped;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - randomized self-checking bench for pwm_gen against a period-position model
module tb_pwm_gen;

  logic        clk;
  logic        n_rst;
  logic        run;
  logic        fault;
  logic        pwm_rdy;
  logic [17:0] off_div;
  logic [9:0]  off_div_w;
  logic [2:0]  p_out;
  logic [2:0]  n_out;
  logic [2:0]  en;
  logic [2:0]  flt;
  logic [17:0] ol0;
  logic [17:0] ol1;
  logic [9:0]  ol2;

  int tests = 0;
  int fails = 0;

  // dut0: defaults, dut1: no dead time, dut2: narrow counter for full-range OFF
  pwm_gen #(.ON_TIME(40), .CNT_WIDTH(18), .DEAD_TIME(2), .MIN_OFF(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .run(run), .fault(fault), .pwm_rdy(pwm_rdy), .off_div(off_div),
    .pwm_out(p_out[0]), .pwm_n_out(n_out[0]), .pwm_en(en[0]), .fault_lat(flt[0]), .off_lat(ol0));
  pwm_gen #(.ON_TIME(40), .CNT_WIDTH(18), .DEAD_TIME(0), .MIN_OFF(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .run(run), .fault(fault), .pwm_rdy(pwm_rdy), .off_div(off_div),
    .pwm_out(p_out[1]), .pwm_n_out(n_out[1]), .pwm_en(en[1]), .fault_lat(flt[1]), .off_lat(ol1));
  pwm_gen #(.ON_TIME(5), .CNT_WIDTH(10), .DEAD_TIME(1), .MIN_OFF(3)) dut2 (
    .clk(clk), .n_rst(n_rst), .run(run), .fault(fault), .pwm_rdy(pwm_rdy), .off_div(off_div_w),
    .pwm_out(p_out[2]), .pwm_n_out(n_out[2]), .pwm_en(en[2]), .fault_lat(flt[2]), .off_lat(ol2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int on_t(int k);
    return (k == 2) ? 5 : 40;
  endfunction
  function automatic int dt_t(int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 1);
  endfunction
  function automatic int min_t(int k);
    return (k == 2) ? 3 : 2;
  endfunction

  // Model: a running flag plus position within the current period.
  bit m_act[3];
  bit m_flt[3];
  int m_pos[3];
  int m_off[3];

  function automatic int clamp_od(int k);
    int od;
    od = (k == 2) ? int'(off_div_w) : int'(off_div);
    return (od < min_t(k)) ? min_t(k) : od;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 3; k++) begin
        m_act[k] <= 1'b0;
        m_flt[k] <= 1'b0;
        m_pos[k] <= 0;
        m_off[k] <= min_t(k);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (fault) begin
          m_act[k] <= 1'b0;
          m_flt[k] <= 1'b1;
        end else if (!run) begin
          m_act[k] <= 1'b0;
          m_flt[k] <= 1'b0;
        end else if (!m_act[k]) begin
          if (!m_flt[k]) begin
            m_act[k] <= 1'b1;
            m_pos[k] <= 0;
            m_off[k] <= clamp_od(k);
          end
        end else if (m_pos[k] == on_t(k) + 2 * dt_t(k) + m_off[k] - 1) begin
          m_pos[k] <= 0;
          if (pwm_rdy) m_off[k] <= clamp_od(k);
        end else begin
          m_pos[k] <= m_pos[k] + 1;
        end
      end
    end
  end

  function automatic logic [21:0] exp_vec(int k);
    int a, b, c;
    logic p, n, e;
    a = on_t(k);
    b = a + dt_t(k);
    c = b + m_off[k];
    p = m_act[k] && (m_pos[k] < a);
    n = m_act[k] && (m_pos[k] >= b) && (m_pos[k] < c);
    e = m_act[k] && (m_pos[k] == b);
    return {p, n, e, m_flt[k], 18'(m_off[k])};
  endfunction

  function automatic logic [21:0] dut_vec(int k);
    case (k)
      0:       return {p_out[0], n_out[0], en[0], flt[0], ol0};
      1:       return {p_out[1], n_out[1], en[1], flt[1], ol1};
      default: return {p_out[2], n_out[2], en[2], flt[2], 8'd0, ol2};
    endcase
  endfunction

  task automatic test_reset();
    n_rst = 1'b0; run = 1'b0; fault = 1'b0; pwm_rdy = 1'b0; off_div = '0; off_div_w = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({p_out[k], n_out[k], en[k], flt[k]} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_outputs dut%0d got %b exp 0000", k, {p_out[k], n_out[k], en[k], flt[k]});
      end
    end
    tests++;
    if (ol0 !== 18'd2 || ol1 !== 18'd2 || ol2 !== 10'd3) begin
      fails++;
      $display("FAIL reset_off_lat got %0d/%0d/%0d exp 2/2/3", ol0, ol1, ol2);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int  rises[$];
    int  ens[$];
    int  falls1;
    bit  prev0, prev1;
    off_div = 18'd100; off_div_w = 10'd20; pwm_rdy = 1'b1; run = 1'b1;
    prev0 = p_out[0]; prev1 = p_out[1]; falls1 = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (dut_vec(k) !== exp_vec(k) || (p_out[k] & n_out[k])) begin
          fails++;
          $display("FAIL nominal_cycle dut%0d t=%0t got %h exp %h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      if (p_out[0] && !prev0) rises.push_back(c);
      if (en[0]) ens.push_back(c);
      if (prev1 && !p_out[1]) begin
        falls1++;
        tests++;
        if (n_out[1] !== 1'b1) begin
          fails++;
          $display("FAIL zero_dt_handover got n=%b exp 1", n_out[1]);
        end
      end
      prev0 = p_out[0]; prev1 = p_out[1];
    end
    tests++;
    if (rises.size() != 3 || rises[1] - rises[0] != 144) begin
      fails++;
      $display("FAIL nominal_period rises=%0d got %0d exp 144", rises.size(),
               (rises.size() > 1) ? rises[1] - rises[0] : -1);
    end
    tests++;
    if (ens.size() != 2 || rises.size() < 2 || ens[0] - rises[0] != 42 || ens[1] - rises[1] != 42) begin
      fails++;
      $display("FAIL nominal_pwm_en count got %0d exp 2 (offset 42)", ens.size());
    end
    tests++;
    if (falls1 != 2) begin
      fails++;
      $display("FAIL zero_dt_periods got %0d exp 2", falls1);
    end
  endtask

  task automatic test_rdy_gating();
    int r[$];
    bit prev;
    prev = p_out[0];
    for (int c = 0; c < 800 && r.size() < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (dut_vec(k) !== exp_vec(k) || (p_out[k] & n_out[k])) begin
          fails++;
          $display("FAIL gating_cycle dut%0d t=%0t got %h exp %h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      if (p_out[0] && !prev) begin
        r.push_back(c);
        if (r.size() == 1) begin pwm_rdy = 1'b0; off_div = 18'd200; end
        if (r.size() == 2) pwm_rdy = 1'b1;
      end
      prev = p_out[0];
    end
    tests++;
    if (r.size() != 4 || r[1] - r[0] != 144 || r[2] - r[1] != 144 || r[3] - r[2] != 244) begin
      fails++;
      $display("FAIL rdy_gating_periods got %0d rises exp 4 with 144/144/244", r.size());
    end
    tests++;
    if (ol0 !== 18'd200) begin
      fails++;
      $display("FAIL rdy_gating_off_lat got %0d exp 200", ol0);
    end
  endtask

  task automatic test_clamp();
    int  r[$];
    int  run_len, first_len;
    bit  prev;
    run = 1'b0;
    @(negedge clk);
    off_div = '0; off_div_w = 10'h3FF; pwm_rdy = 1'b1; run = 1'b1;
    prev = 1'b0; run_len = 0; first_len = -1;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (dut_vec(k) !== exp_vec(k) || (p_out[k] & n_out[k])) begin
          fails++;
          $display("FAIL clamp_cycle dut%0d t=%0t got %h exp %h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      if (p_out[0] && !prev) r.push_back(c);
      prev = p_out[0];
      if (n_out[2]) run_len++;
      else if (run_len > 0 && first_len < 0) first_len = run_len;
    end
    tests++;
    if (r.size() < 2 || r[1] - r[0] != 46 || ol0 !== 18'd2) begin
      fails++;
      $display("FAIL clamp_zero got off_lat %0d exp 2 (period 46)", ol0);
    end
    tests++;
    if (first_len != 1023 || ol2 !== 10'h3FF) begin
      fails++;
      $display("FAIL max_off_no_wrap got %0d exp 1023", first_len);
    end
  endtask

  task automatic test_fault();
    bit prev, seen;
    off_div = 18'd100;
    prev = p_out[0]; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (p_out[0] && !prev) seen = 1'b1;
      prev = p_out[0];
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL fault_wait_on got no rise exp rise within 300");
    end
    repeat (5) @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    tests++;
    if ({p_out[0], n_out[0], flt[0]} !== 3'b001) begin
      fails++;
      $display("FAIL fault_trip got %b exp 001", {p_out[0], n_out[0], flt[0]});
    end
    fault = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (dut_vec(k) !== exp_vec(k) || p_out[k] !== 1'b0) begin
          fails++;
          $display("FAIL fault_hold dut%0d got %h exp %h", k, dut_vec(k), exp_vec(k));
        end
      end
    end
    run = 1'b0;
    @(negedge clk);
    tests++;
    if (flt[0] !== 1'b0) begin
      fails++;
      $display("FAIL fault_clear got %b exp 0", flt[0]);
    end
    run = 1'b1;
    @(negedge clk);
    tests++;
    if (p_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL fault_restart got %b exp 1", p_out[0]);
    end
  endtask

  task automatic test_reset_and_run_drop();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = n_out[0];
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    tests++;
    if (!seen || (p_out | n_out) !== 3'b000) begin
      fails++;
      $display("FAIL async_reset_gates got %b/%b exp 000/000", p_out, n_out);
    end
    @(negedge clk);
    n_rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = n_out[0];
    end
    repeat (3) @(negedge clk);
    run = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (!seen || dut_vec(k) !== exp_vec(k) || {p_out[k], n_out[k], en[k]} !== 3'b000) begin
          fails++;
          $display("FAIL run_drop dut%0d got %h exp %h", k, dut_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (dut_vec(k) !== exp_vec(k) || (p_out[k] & n_out[k])) begin
          fails++;
          $display("FAIL random_cycle dut%0d t=%0t got %h exp %h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      off_div   = 18'($urandom_range(0, 40));
      off_div_w = 10'($urandom_range(0, 30));
      pwm_rdy   = 1'($urandom_range(0, 1));
      if (!run) run = 1'b1;
      else if ($urandom_range(0, 199) == 0) run = 1'b0;
      fault = ($urandom_range(0, 299) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_rdy_gating();
    test_clamp();
    test_fault();
    test_reset_and_run_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
